// File: rtl/gpio_config_loader.sv
// Loads per-pad GPIO configuration words into the two serial chains, then strobes load.
// Optional: GPIO_LOADER_AUTOSTART_EN starts one sequence right after reset release.
module gpio_config_loader #(
    parameter int NUM_IO   = 38,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [5:0]          cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_rdata,
    output logic                serial_clock,
    output logic                serial_load,
    output logic                serial_resetn,
    output logic                serial_data_1,
    output logic                serial_data_2
);

    localparam int CHAIN_LEN = NUM_IO / 2;
    localparam int WW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int CW = $clog2(2 * CLK_DIV) + 1;

    typedef enum logic [2:0] {
        IDLE, FETCH_A, FETCH_B, FETCH_C,
        SHIFT_LO, SHIFT_HI, LOAD, DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CW-1:0]       r_cnt, w_cnt_nxt;
    logic [BW-1:0]       r_bit, w_bit_nxt;
    logic [WW-1:0]       r_w, w_w_nxt;
    logic [CFG_BITS-1:0] r_sr1, w_sr1_nxt;
    logic [CFG_BITS-1:0] r_sr2, w_sr2_nxt;
    logic                r_start_q;
    logic                r_busy, r_done, r_sclk, r_load, r_resetn;
    logic [5:0]          r_addr;
    logic                w_auto;

`ifdef GPIO_LOADER_AUTOSTART_EN
    logic r_armed;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_armed <= 1'b1;
        end else begin
            r_armed <= 1'b0;
        end
    end

    assign w_auto = r_armed;
`else
    assign w_auto = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_w_nxt     = r_w;
        w_sr1_nxt   = r_sr1;
        w_sr2_nxt   = r_sr2;
        unique case (r_state)
            IDLE: begin
                if (r_start_q) begin
                    w_state_nxt = FETCH_A;
                    w_w_nxt     = '0;
                end
            end
            FETCH_A: w_state_nxt = FETCH_B;
            FETCH_B: begin
                w_sr1_nxt   = cfg_rdata;
                w_state_nxt = FETCH_C;
            end
            FETCH_C: begin
                w_sr2_nxt   = cfg_rdata;
                w_bit_nxt   = BW'(CFG_BITS - 1);
                w_cnt_nxt   = '0;
                w_state_nxt = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (r_cnt == CW'(CLK_DIV - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT_HI;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            SHIFT_HI: begin
                if (r_cnt == CW'(CLK_DIV - 1)) begin
                    w_cnt_nxt = '0;
                    w_sr1_nxt = {r_sr1[CFG_BITS-2:0], 1'b0};
                    w_sr2_nxt = {r_sr2[CFG_BITS-2:0], 1'b0};
                    if (r_bit != '0) begin
                        w_bit_nxt   = r_bit - BW'(1);
                        w_state_nxt = SHIFT_LO;
                    end else if (r_w != WW'(CHAIN_LEN - 1)) begin
                        w_w_nxt     = r_w + WW'(1);
                        w_state_nxt = FETCH_A;
                    end else begin
                        w_state_nxt = LOAD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            LOAD: begin
                if (r_cnt == CW'(2 * CLK_DIV - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from next-state so the chain pins are glitch-free
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_w       <= '0;
            r_sr1     <= '0;
            r_sr2     <= '0;
            r_start_q <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_load    <= 1'b0;
            r_resetn  <= 1'b0;
            r_addr    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_w       <= w_w_nxt;
            r_sr1     <= w_sr1_nxt;
            r_sr2     <= w_sr2_nxt;
            r_start_q <= (r_state == IDLE) && (w_state_nxt == IDLE)
                         && (start || w_auto);
            r_busy    <= (w_state_nxt != IDLE);
            r_done    <= (w_state_nxt == DONE);
            r_sclk    <= (w_state_nxt == SHIFT_HI);
            r_load    <= (w_state_nxt == LOAD) && (w_cnt_nxt < CW'(CLK_DIV));
            r_resetn  <= 1'b1;
            if (w_state_nxt == FETCH_A) begin
                r_addr <= 6'(CHAIN_LEN - 1) - 6'(w_w_nxt);
            end else if (w_state_nxt == FETCH_B) begin
                r_addr <= 6'(CHAIN_LEN) + 6'(r_w);
            end
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign cfg_addr      = r_addr;
    assign serial_clock  = r_sclk;
    assign serial_load   = r_load;
    assign serial_resetn = r_resetn;
    assign serial_data_1 = r_sr1[CFG_BITS-1];
    assign serial_data_2 = r_sr2[CFG_BITS-1];

endmodule

// File: tb/tb_gpio_config_loader.sv
// Bench for gpio_config_loader: register-file model, two behavioural pad chains,
// vector table of load runs plus reset / autostart sequences.
module tb_gpio_config_loader;

    localparam int NUM_IO   = 38;
    localparam int CFG_BITS = 13;
    localparam int CLK_DIV  = 2;
    localparam int CL       = NUM_IO / 2;
    localparam int WORD_CYC = 3 + 2 * CLK_DIV * CFG_BITS;
    localparam int BUSY_LEN = CL * WORD_CYC + 2 * CLK_DIV + 1;
    localparam int NVEC     = 6;
`ifdef GPIO_LOADER_AUTOSTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic                clock;
    logic                reset;
    logic                start;
    logic                busy;
    logic                done;
    logic [5:0]          cfg_addr;
    logic [CFG_BITS-1:0] cfg_rdata;
    logic                serial_clock;
    logic                serial_load;
    logic                serial_resetn;
    logic                serial_data_1;
    logic                serial_data_2;

    gpio_config_loader #(
        .NUM_IO(NUM_IO), .CFG_BITS(CFG_BITS), .CLK_DIV(CLK_DIV)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .busy(busy), .done(done), .cfg_addr(cfg_addr),
        .cfg_rdata(cfg_rdata), .serial_clock(serial_clock),
        .serial_load(serial_load), .serial_resetn(serial_resetn),
        .serial_data_1(serial_data_1), .serial_data_2(serial_data_2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Register file with one-cycle read latency
    logic [CFG_BITS-1:0] regfile [NUM_IO];
    always @(posedge clock) begin
        if (int'(cfg_addr) < NUM_IO) cfg_rdata <= regfile[int'(cfg_addr)];
        else cfg_rdata <= '0;
    end

    // Behavioural chains: shift on serial_clock rise, latch on serial_load rise
    bit                     mon_en;
    bit                     alt_mode;
    int                     busy_cyc, done_cnt, load_cnt, viol, alt_viol, rise_n;
    int                     stable, hi;
    logic                   prev_d1, prev_d2, prev_sclk, prev_load, prev_done;
    logic                   first1, first2, chg;
    logic [5:0]             prev_addr;
    logic [5:0]             addr_q [$];
    logic [CFG_BITS*CL-1:0] ch1, ch2;
    logic [CFG_BITS-1:0]    pad_cfg [NUM_IO];
    logic                   exp_bit;

    always @(negedge clock) begin
        if (mon_en) begin
            if (busy) busy_cyc++;
            if (done) done_cnt++;
            if (done && !busy) viol++;
            if (prev_done && busy) viol++;
            chg = (serial_data_1 != prev_d1) || (serial_data_2 != prev_d2);
            if (chg && serial_clock) viol++;
            stable = chg ? 1 : stable + 1;
            if (serial_clock && !prev_sclk) begin
                if (stable < CLK_DIV + 1) viol++;
                if (rise_n == 0) begin
                    first1 = serial_data_1;
                    first2 = serial_data_2;
                end
                exp_bit = ((rise_n % CFG_BITS) % 2) == 0;
                if (alt_mode && (serial_data_1 != exp_bit || serial_data_2 != exp_bit))
                    alt_viol++;
                ch1 = {ch1[CFG_BITS*CL-2:0], serial_data_1};
                ch2 = {ch2[CFG_BITS*CL-2:0], serial_data_2};
                rise_n++;
            end
            if (serial_clock) begin
                hi++;
            end else begin
                if (prev_sclk && hi != CLK_DIV) viol++;
                hi = 0;
            end
            if (serial_load && !prev_load) begin
                load_cnt++;
                for (int k = 0; k < CL; k++) begin
                    pad_cfg[k]      = ch1[CFG_BITS*k +: CFG_BITS];
                    pad_cfg[CL + k] = ch2[CFG_BITS*(CL-1-k) +: CFG_BITS];
                end
            end
            if (busy && cfg_addr != prev_addr) addr_q.push_back(cfg_addr);
        end
        prev_d1   = serial_data_1;
        prev_d2   = serial_data_2;
        prev_sclk = serial_clock;
        prev_load = serial_load;
        prev_done = done;
        prev_addr = cfg_addr;
    end

    task automatic clear_mon(input bit alt);
        busy_cyc = 0; done_cnt = 0; load_cnt = 0;
        viol = 0; alt_viol = 0; rise_n = 0;
        stable = 100; hi = 0;
        first1 = 1'b0; first2 = 1'b0;
        alt_mode = alt;
        ch1 = '0; ch2 = '0;
        addr_q.delete();
        for (int i = 0; i < NUM_IO; i++) pad_cfg[i] = '0;
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < NUM_IO; i++) begin
            case (mode)
                0: regfile[i] = 13'h1000 | CFG_BITS'(i);
                1: regfile[i] = 13'h1555;
                default: regfile[i] = CFG_BITS'($urandom);
            endcase
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_addr"}, int'(cfg_addr), 0);
        chk({tag, "_sclk"}, int'(serial_clock), 0);
        chk({tag, "_load"}, int'(serial_load), 0);
        chk({tag, "_resetn"}, int'(serial_resetn), 0);
        chk({tag, "_d1"}, int'(serial_data_1), 0);
        chk({tag, "_d2"}, int'(serial_data_2), 0);
    endtask

    typedef struct {
        int mode;
        int extra_at;
        int exp_busy;
        int exp_done;
        int exp_load;
    } vec_t;

    task automatic run_seq(input vec_t v, input bit do_start, input string tag);
        bit seen, fin;
        int bc, bad_addr, bad_pad;
        fill(v.mode);
        @(posedge clock);
        clear_mon(v.mode == 1);
        mon_en = 1'b1;
        if (do_start) begin
            @(negedge clock);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        seen = 1'b0;
        fin  = 1'b0;
        bc   = 0;
        for (int c = 0; c < BUSY_LEN + 200 && !fin; c++) begin
            @(negedge clock);
            if (busy) begin
                seen = 1'b1;
                bc++;
            end else if (seen) begin
                fin = 1'b1;
            end
            start = (v.extra_at > 0) && (bc == v.extra_at) && busy;
        end
        start = 1'b0;
        repeat (3) @(negedge clock);
        @(posedge clock);
        mon_en = 1'b0;
        chk({tag, "_complete"}, int'(fin), 1);
        chk({tag, "_busy_len"}, busy_cyc, v.exp_busy);
        chk({tag, "_done_cnt"}, done_cnt, v.exp_done);
        chk({tag, "_load_cnt"}, load_cnt, v.exp_load);
        chk({tag, "_timing"}, viol, 0);
        chk({tag, "_rises"}, rise_n, CL * CFG_BITS * 2 / 2);
        bad_addr = 0;
        chk({tag, "_addr_len"}, addr_q.size(), 2 * CL);
        for (int w = 0; w < CL; w++) begin
            if (addr_q.size() >= 2 * w + 2) begin
                if (int'(addr_q[2*w]) != CL - 1 - w) bad_addr++;
                if (int'(addr_q[2*w+1]) != CL + w) bad_addr++;
            end
        end
        chk({tag, "_addr_seq"}, bad_addr, 0);
        bad_pad = 0;
        for (int i = 0; i < NUM_IO; i++) begin
            if (pad_cfg[i] != regfile[i]) begin
                bad_pad++;
                if (bad_pad == 1)
                    chk($sformatf("%s_pad%0d", tag, i), int'(pad_cfg[i]), int'(regfile[i]));
            end
        end
        chk({tag, "_pads_bad"}, bad_pad, 0);
        if (v.mode == 1) begin
            chk({tag, "_first1"}, int'(first1), 1);
            chk({tag, "_first2"}, int'(first2), 1);
            chk({tag, "_alternate"}, alt_viol, 0);
        end
    endtask

    vec_t tbl [NVEC];

    initial begin
        int bad, bc;
        bit fin;
        tbl[0] = '{0, 0, BUSY_LEN, 1, 1};
        tbl[1] = '{1, 0, BUSY_LEN, 1, 1};
        tbl[2] = '{0, 200, BUSY_LEN, 1, 1};
        tbl[3] = '{2, BUSY_LEN, BUSY_LEN, 1, 1};
        tbl[4] = '{2, int'($urandom_range(1, BUSY_LEN)), BUSY_LEN, 1, 1};
        tbl[5] = '{2, 0, BUSY_LEN, 1, 1};

        mon_en = 1'b0;
        start  = 1'b0;
        reset  = 1'b1;
        fill(0);
        clear_mon(1'b0);
        #1;
        chk_reset_vals("por");
        repeat (3) @(negedge clock);
        chk_reset_vals("por_hold");

        mon_en = 1'b1;
        reset  = 1'b0;
        @(negedge clock);
        chk("resetn_rise", int'(serial_resetn), 1);
        if (AUTO) begin
            @(negedge clock);
            chk("autostart_busy", int'(busy), 1);
            fin = 1'b0;
            for (int c = 0; c < BUSY_LEN + 200 && !fin; c++) begin
                @(negedge clock);
                if (!busy) fin = 1'b1;
            end
            @(negedge clock);
            chk("autostart_complete", int'(fin), 1);
            chk("autostart_done", done_cnt, 1);
            chk("autostart_pads_0", int'(pad_cfg[0]), int'(13'h1000));
        end else begin
            bad = 0;
            for (int c = 0; c < 2000; c++) begin
                @(negedge clock);
                if (busy) bad++;
            end
            chk("no_autostart_idle", bad, 0);
        end
        mon_en = 1'b0;

        for (int i = 0; i < NVEC; i++)
            run_seq(tbl[i], 1'b1, $sformatf("vec%0d", i));

        // Reset in the middle of a sequence
        fill(0);
        @(posedge clock);
        clear_mon(1'b0);
        mon_en = 1'b1;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        bc = 0;
        for (int c = 0; c < 1000 && bc < 500; c++) begin
            @(negedge clock);
            if (busy) bc++;
        end
        chk("midreset_reached", bc, 500);
        reset  = 1'b1;
        mon_en = 1'b0;
        #1;
        chk_reset_vals("midreset");
        chk("midreset_no_load", load_cnt, 0);
        repeat (4) @(negedge clock);
        chk("midreset_hold_load", int'(serial_load), 0);
        chk("midreset_hold_busy", int'(busy), 0);
        reset = 1'b0;
        run_seq(tbl[0], !AUTO, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
